pmem_fetch_0: RTL and testbench

- Instruction-fetch requester for the 1-cycle-latency program memory read port.
- Drives pc_read_c0 and captures instr_reg_c1 one cycle later.
- Buffers returned words in a 2-entry FIFO tagged with their PC, and presents them to decode on a valid/ready handshake.
- Handles control-flow redirects by flushing the FIFO and discarding the stale in-flight read.

---
 rtl/pmem_fetch_0_if.sv | 37 +++
 rtl/pmem_fetch_0.sv | 115 +++++++++++
 tb/tb_pmem_fetch_0.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_fetch_0_if.sv
// Fetch-side bundle: program memory read port plus the decode valid/ready
// handshake and redirect request. The master modport belongs to the fetch unit.
interface pmem_fetch_0_if #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 32
);
  logic [PC_W-1:0]    pc_read_c0;
  logic [INSTR_W-1:0] instr_reg_c1;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_ready;

  modport master (
    output pc_read_c0,
    input  instr_reg_c1,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  pc_read_c0,
    output instr_reg_c1,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/pmem_fetch_0.sv
// Instruction fetch requester for a 1-cycle-latency program memory with a 2-entry
// PC-tagged buffer. Define PMEM_FETCH_STATS_EN to add pop/flush statistics counters.
module pmem_fetch_0 #(
  parameter int              PC_W     = 10,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pmem_fetch_0_if.master        bus
`ifdef PMEM_FETCH_STATS_EN
  ,
  output logic [31:0]           stat_fetch_cnt,
  output logic [31:0]           stat_flush_cnt
`endif
);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic               inflight_q, inflight_d;
  logic [PC_W-1:0]    inflight_pc_q, inflight_pc_d;
  logic [INSTR_W-1:0] fifo_instr_q [2];
  logic [PC_W-1:0]    fifo_pc_q [2];
  logic [1:0]         count_q, count_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;

  logic               redirect;
  logic               pop;
  logic               push;
  logic               issue;
  logic [1:0]         occupancy;

  assign bus.pc_read_c0  = pc_q;
  assign bus.instr_valid = (count_q != 2'd0);
  assign bus.instr       = fifo_instr_q[rd_q];
  assign bus.instr_pc    = fifo_pc_q[rd_q];

  always_comb begin
    redirect      = bus.redirect_valid;
    pop           = bus.instr_valid & bus.instr_ready;
    push          = inflight_q & ~redirect;
    // Slots already claimed after this cycle's pop; never exceeds 2 because a
    // pending response only exists when at most one entry is buffered.
    occupancy     = count_q + {1'b0, inflight_q} - {1'b0, pop};
    issue         = ~redirect & (occupancy < 2'd2);

    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q + {1'b0, push} - {1'b0, pop};
    rd_d          = rd_q ^ pop;
    wr_d          = wr_q ^ push;

    if (issue) begin
      pc_d          = pc_q + PC_W'(4);
      inflight_pc_d = pc_q;
    end

    if (redirect) begin
      pc_d       = bus.redirect_pc & ~PC_W'(3);
      inflight_d = 1'b0;
      count_d    = '0;
      rd_d       = 1'b0;
      wr_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      if (push) begin
        fifo_instr_q[wr_q] <= bus.instr_reg_c1;
        fifo_pc_q[wr_q]    <= inflight_pc_q;
      end
    end
  end

`ifdef PMEM_FETCH_STATS_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pop)      fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (redirect) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stat_fetch_cnt = fetch_cnt_q;
  assign stat_flush_cnt = flush_cnt_q;
`endif

  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!rst_n) push |-> (count_q != 2'd2)
  );

endmodule

// File: tb/tb_pmem_fetch_0.sv
// Directed + randomized bench for pmem_fetch_0 against an in-order fetch-stream model.
module tb_pmem_fetch_0;
  localparam int PC_W    = 10;
  localparam int INSTR_W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pmem_fetch_0_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

`ifdef PMEM_FETCH_STATS_EN
  logic [31:0] stat_fetch_cnt, stat_flush_cnt;
`endif

  pmem_fetch_0 #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(10'h000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef PMEM_FETCH_STATS_EN
    ,
    .stat_fetch_cnt (stat_fetch_cnt),
    .stat_flush_cnt (stat_flush_cnt)
`endif
  );

  logic [31:0] rom [256];
  always @(posedge clk) bus.instr_reg_c1 <= rom[bus.pc_read_c0[9:2]];

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          pops;
  int          flushes;
  logic [9:0]  exp_pc;
  logic        prev_hold;
  logic [9:0]  prev_pc;
  logic [31:0] prev_instr;
  logic [9:0]  stall_addr;
  int          rand_pops;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, score any transfer, then advance to 1 time unit past the edge.
  task automatic cycle(input logic rdy, input logic redir, input logic [9:0] rpc);
    logic p;
    bus.instr_ready    = rdy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    if (prev_hold) begin
      check("hold_valid", 32'(bus.instr_valid), 32'd1);
      check("hold_pc",    32'(bus.instr_pc),    32'(prev_pc));
      check("hold_instr", bus.instr,            prev_instr);
    end
    p = bus.instr_valid && rdy;
    if (p) begin
      check("stream_pc",    32'(bus.instr_pc), 32'(exp_pc));
      check("stream_instr", bus.instr,         rom[exp_pc[9:2]]);
      exp_pc = exp_pc + 10'd4;
      pops++;
    end
    if (redir) begin
      exp_pc = rpc & 10'h3FC;
      flushes++;
    end
    prev_hold  = bus.instr_valid && !rdy && !redir;
    prev_pc    = bus.instr_pc;
    prev_instr = bus.instr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag);
`ifdef PMEM_FETCH_STATS_EN
    check({tag, "_fetch_cnt"}, stat_fetch_cnt, 32'(pops));
    check({tag, "_flush_cnt"}, stat_flush_cnt, 32'(flushes));
`else
    if (tag.len() == 0) $display("stats disabled");
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[0]   = 32'h00000113;
    rom[1]   = 32'h00000413;
    rom[2]   = 32'h00000013;
    rom[29]  = 32'hff010113;
    rom[30]  = 32'h012347b7;
    rom[255] = 32'h00112623;

    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    prev_hold = 1'b0;
    exp_pc    = 10'h000;
    pops      = 0;
    flushes   = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc_read", 32'(bus.pc_read_c0),  32'h0);
    check("rst_valid",   32'(bus.instr_valid), 32'h0);
    check("rst_instr",   bus.instr,            32'h0);
    check("rst_instr_pc",32'(bus.instr_pc),    32'h0);
    check_stats("rst");
    rst_n = 1'b1;

    // First fetch latency and opening stream
    check("issue0_addr", 32'(bus.pc_read_c0), 32'h000);
    check("c0_valid",    32'(bus.instr_valid), 32'h0);
    cycle(1'b1, 1'b0, '0);
    check("c1_valid",    32'(bus.instr_valid), 32'h0);
    cycle(1'b1, 1'b0, '0);
    check("c2_valid",    32'(bus.instr_valid), 32'h1);
    check("c2_pc",       32'(bus.instr_pc),    32'h000);
    check("c2_instr",    bus.instr,            32'h00000113);
    cycle(1'b1, 1'b0, '0);
    check("c3_pc",       32'(bus.instr_pc),    32'h004);
    check("c3_instr",    bus.instr,            32'h00000413);
    cycle(1'b1, 1'b0, '0);
    check("c4_pc",       32'(bus.instr_pc),    32'h008);
    check("c4_instr",    bus.instr,            32'h00000013);
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      check("stream_no_gap", 32'(bus.instr_valid), 32'h1);
      cycle(1'b1, 1'b0, '0);
    end

    // Backpressure for 10 cycles
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    stall_addr = bus.pc_read_c0;
    for (int i = 0; i < 8; i++) begin
      check("stall_pc_frozen", 32'(bus.pc_read_c0), 32'(stall_addr));
      cycle(1'b0, 1'b0, '0);
    end
    for (int i = 0; i < 6; i++) begin
      check("resume_no_gap", 32'(bus.instr_valid), 32'h1);
      cycle(1'b1, 1'b0, '0);
    end

    // Redirect to 0x074 with buffer full
    repeat (3) cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 10'h074);
    check("redir74_drop",  32'(bus.instr_valid), 32'h0);
    check("redir74_issue", 32'(bus.pc_read_c0),  32'h074);
    cycle(1'b1, 1'b0, '0);
    check("redir74_gap",   32'(bus.instr_valid), 32'h0);
    cycle(1'b1, 1'b0, '0);
    check("redir74_valid", 32'(bus.instr_valid), 32'h1);
    check("redir74_pc",    32'(bus.instr_pc),    32'h074);
    check("redir74_instr", bus.instr,            32'hff010113);
    cycle(1'b1, 1'b0, '0);
    check("redir78_pc",    32'(bus.instr_pc),    32'h078);
    check("redir78_instr", bus.instr,            32'h012347b7);
    cycle(1'b1, 1'b0, '0);

    // Wrap at the top of the address space
    cycle(1'b1, 1'b1, 10'h3FC);
    check("wrap_drop", 32'(bus.instr_valid), 32'h0);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    check("wrap_pc_top",    32'(bus.instr_pc), 32'h3FC);
    check("wrap_instr_top", bus.instr,         32'h00112623);
    cycle(1'b1, 1'b0, '0);
    check("wrap_pc_zero",    32'(bus.instr_pc), 32'h000);
    check("wrap_instr_zero", bus.instr,         32'h00000113);
    cycle(1'b1, 1'b0, '0);

    // Misaligned redirect target with a pop in the same cycle
    check("pre_redir_valid", 32'(bus.instr_valid), 32'h1);
    cycle(1'b1, 1'b1, 10'h0E6);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    check("align_pc",    32'(bus.instr_pc), 32'h0E4);
    check("align_instr", bus.instr,         rom[57]);
    cycle(1'b1, 1'b0, '0);
    check("align_next_pc", 32'(bus.instr_pc), 32'h0E8);
    cycle(1'b1, 1'b0, '0);

    // Back-to-back redirects: last wins
    cycle(1'b1, 1'b1, 10'h100);
    cycle(1'b1, 1'b1, 10'h200);
    check("b2b_drop1", 32'(bus.instr_valid), 32'h0);
    cycle(1'b1, 1'b0, '0);
    check("b2b_drop2", 32'(bus.instr_valid), 32'h0);
    cycle(1'b1, 1'b0, '0);
    check("b2b_pc",    32'(bus.instr_pc),    32'h200);
    check("b2b_valid", 32'(bus.instr_valid), 32'h1);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    check_stats("mid");

    // Asynchronous reset pulse mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid",   32'(bus.instr_valid), 32'h0);
    check("arst_instr",   bus.instr,            32'h0);
    check("arst_instr_pc",32'(bus.instr_pc),    32'h0);
    check("arst_pc_read", 32'(bus.pc_read_c0),  32'h0);
    @(posedge clk);
    #3;
    rst_n     = 1'b1;
    prev_hold = 1'b0;
    exp_pc    = 10'h000;
    pops      = 0;
    flushes   = 0;
    check_stats("arst");
    check("arst_c0_valid", 32'(bus.instr_valid), 32'h0);
    bus.instr_ready = 1'b1;
    @(posedge clk);
    #1;
    check("arst_c1_valid", 32'(bus.instr_valid), 32'h0);
    cycle(1'b1, 1'b0, '0);
    check("arst_restart_valid", 32'(bus.instr_valid), 32'h1);
    check("arst_restart_pc",    32'(bus.instr_pc),    32'h000);
    check("arst_restart_instr", bus.instr,            32'h00000113);

    // Randomized traffic against the stream model
    rand_pops = pops;
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0), 10'($urandom));
    end
    repeat (8) cycle(1'b1, 1'b0, '0);
    check("rand_liveness", 32'(pops - rand_pops >= 50), 32'h1);
    check_stats("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
